// File: rtl/vga_mem_arbiter_if.sv
// Writer request bus plus single-port image memory bus shared through vga_mem_arbiter.
// slave = arbiter side, master = writer/memory side.
interface vga_mem_arbiter_if #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 8
);
  logic              wr_valid;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  wr_valid, wr_addr, wr_data, mem_rdata,
    output wr_ready, mem_addr, mem_we, mem_wdata
  );

  modport master (
    output wr_valid, wr_addr, wr_data, mem_rdata,
    input  wr_ready, mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/vga_mem_arbiter.sv
// Arbitrates the image memory port between the VGA beam (absolute priority inside
// the tiled window) and the image writer; returns display pixels two cycles after the grant.
module vga_mem_arbiter #(
  parameter int ADDR_W   = 18,
  parameter int DATA_W   = 8,
  parameter int X0       = 120,
  parameter int Y0       = 40,
  parameter int TILE     = 100,
  parameter int TILES    = 4,
  parameter int MAX_WAIT = 1023
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [9:0]          x,
  input  logic [9:0]          y,
  vga_mem_arbiter_if.slave    bus,
  output logic                pix_valid,
  output logic [DATA_W-1:0]   pix_data,
  output logic                frame_done,
  input  logic                clear_status,
  output logic                wr_oob,
  output logic                starve
);
  localparam int WIN    = TILES * TILE;
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  localparam logic [9:0] X_LO   = 10'(X0);
  localparam logic [9:0] X_HI   = 10'(X0 + WIN);
  localparam logic [9:0] Y_LO   = 10'(Y0);
  localparam logic [9:0] Y_HI   = 10'(Y0 + WIN);
  localparam logic [9:0] X_LAST = 10'(X0 + WIN - 1);
  localparam logic [9:0] Y_LAST = 10'(Y0 + WIN - 1);
  localparam logic [9:0] TILE_C = 10'(TILE);

  localparam logic [ADDR_W-1:0] TILE_A    = ADDR_W'(TILE);
  localparam logic [ADDR_W-1:0] TILES_A   = ADDR_W'(TILES);
  localparam logic [ADDR_W-1:0] AREA_A    = ADDR_W'(TILE * TILE);
  localparam logic [ADDR_W-1:0] MEM_WORDS = ADDR_W'(TILES * TILES * TILE * TILE);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MAX_WAIT);

  typedef enum logic [1:0] {
    GNT_IDLE  = 2'd0,
    GNT_DISP  = 2'd1,
    GNT_WRITE = 2'd2
  } grant_e;

  // Tiles are stored row-major, each tile's pixels contiguous and row-major inside it.
  function automatic logic [ADDR_W-1:0] tile_addr(input logic [9:0] dx, input logic [9:0] dy);
    logic [ADDR_W-1:0] bx, lx, by, ly;
    bx = ADDR_W'(dx / TILE_C);
    lx = ADDR_W'(dx % TILE_C);
    by = ADDR_W'(dy / TILE_C);
    ly = ADDR_W'(dy % TILE_C);
    return (by * TILES_A + bx) * AREA_A + ly * TILE_A + lx;
  endfunction

  grant_e              grant_d, grant_q;
  logic [ADDR_W-1:0]   mem_addr_d, mem_addr_q;
  logic                mem_we_d, mem_we_q;
  logic [DATA_W-1:0]   mem_wdata_d, mem_wdata_q;
  logic                pix_valid_d, pix_valid_q;
  logic [DATA_W-1:0]   pix_hold_d, pix_hold_q;
  logic                last_d, last_q;
  logic                frame_done_d, frame_done_q;
  logic                wr_oob_d, wr_oob_q;
  logic                starve_d, starve_q;
  logic [WAIT_W-1:0]   wait_d, wait_q;
  logic                in_win_s, wr_ready_s, waiting_s, oob_set_s, starve_set_s;

  always_comb begin
    in_win_s   = enable && (x >= X_LO) && (x < X_HI) && (y >= Y_LO) && (y < Y_HI);
    wr_ready_s = !reset && !in_win_s;
    waiting_s  = bus.wr_valid && !wr_ready_s;

    if (in_win_s) begin
      grant_d = GNT_DISP;
    end else if (bus.wr_valid) begin
      grant_d = GNT_WRITE;
    end else begin
      grant_d = GNT_IDLE;
    end

    mem_addr_d  = mem_addr_q;
    mem_we_d    = 1'b0;
    mem_wdata_d = mem_wdata_q;
    oob_set_s   = 1'b0;
    case (grant_d)
      GNT_DISP: mem_addr_d = tile_addr(x - X_LO, y - Y_LO);
      GNT_WRITE: begin
        mem_addr_d  = bus.wr_addr;
        mem_wdata_d = bus.wr_data;
        mem_we_d    = (bus.wr_addr < MEM_WORDS);
        oob_set_s   = !(bus.wr_addr < MEM_WORDS);
      end
      default: mem_we_d = 1'b0;
    endcase

    // grant_q is the previous cycle's decision; its read data arrives one cycle later.
    pix_valid_d  = (grant_q == GNT_DISP);
    pix_hold_d   = pix_valid_q ? bus.mem_rdata : pix_hold_q;
    last_d       = in_win_s && (x == X_LAST) && (y == Y_LAST);
    frame_done_d = last_q;

    if (waiting_s) begin
      wait_d = (wait_q == WAIT_MAX) ? wait_q : wait_q + WAIT_W'(1);
    end else begin
      wait_d = '0;
    end
    starve_set_s = waiting_s && (wait_d == WAIT_MAX);

    if (oob_set_s) begin
      wr_oob_d = 1'b1;
    end else if (clear_status) begin
      wr_oob_d = 1'b0;
    end else begin
      wr_oob_d = wr_oob_q;
    end

    if (starve_set_s) begin
      starve_d = 1'b1;
    end else if (clear_status) begin
      starve_d = 1'b0;
    end else begin
      starve_d = starve_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      grant_q      <= GNT_IDLE;
      mem_addr_q   <= '0;
      mem_we_q     <= 1'b0;
      mem_wdata_q  <= '0;
      pix_valid_q  <= 1'b0;
      pix_hold_q   <= '0;
      last_q       <= 1'b0;
      frame_done_q <= 1'b0;
      wr_oob_q     <= 1'b0;
      starve_q     <= 1'b0;
      wait_q       <= '0;
    end else begin
      grant_q      <= grant_d;
      mem_addr_q   <= mem_addr_d;
      mem_we_q     <= mem_we_d;
      mem_wdata_q  <= mem_wdata_d;
      pix_valid_q  <= pix_valid_d;
      pix_hold_q   <= pix_hold_d;
      last_q       <= last_d;
      frame_done_q <= frame_done_d;
      wr_oob_q     <= wr_oob_d;
      starve_q     <= starve_d;
      wait_q       <= wait_d;
    end
  end

  // Read data is only valid in the pixel cycle, so it is passed through there and held after.
  assign pix_data      = pix_valid_q ? bus.mem_rdata : pix_hold_q;
  assign pix_valid     = pix_valid_q;
  assign frame_done    = frame_done_q;
  assign wr_oob        = wr_oob_q;
  assign starve        = starve_q;
  assign bus.wr_ready  = wr_ready_s;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_wdata = mem_wdata_q;
endmodule

// File: doc/vga_mem_arbiter.md
Name: vga_mem_arbiter

Overview:
Owns the single-port image memory (160000 words, 4x4 tiles of 100x100) shared by the VGA display path and the image-processing writer. Each cycle it grants the port to the display when the beam (x,y) is inside the 400x400 window, and to the writer otherwise. It generates the tiled display read address and returns pixels with fixed latency. It also reports end-of-frame, out-of-range writes and writer starvation.

Parameters:
ADDR_W, 18, memory address width
DATA_W, 8, pixel/memory word width
X0, 120, first window column
Y0, 40, first window row
TILE, 100, tile edge in pixels
TILES, 4, tiles per row/column (window = TILES*TILE square)
MAX_WAIT, 1023, writer wait cycles before starvation flag

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
enable  in  1  1 = display arbitration active; 0 = writer owns port
x  in  10  current beam column
y  in  10  current beam row
wr_valid  in  1  writer request
wr_addr  in  ADDR_W  writer address
wr_data  in  DATA_W  writer data
wr_ready  out  1  writer accepted this cycle (combinational)
mem_addr  out  ADDR_W  memory address (registered)
mem_we  out  1  memory write enable (registered)
mem_wdata  out  DATA_W  memory write data (registered)
mem_rdata  in  DATA_W  memory read data, valid 1 cycle after mem_addr
pix_valid  out  1  pix_data holds a window pixel
pix_data  out  DATA_W  display pixel
frame_done  out  1  one-cycle pulse with last window pixel
clear_status  in  1  clears wr_oob and starve
wr_oob  out  1  sticky: write address >= TILES*TILES*TILE*TILE dropped
starve  out  1  sticky: writer waited MAX_WAIT consecutive cycles

Behaviour:
- Reset (synchronous, active-high): mem_addr=0, mem_we=0, mem_wdata=0, pix_valid=0, pix_data=0, frame_done=0, wr_oob=0, starve=0, wait counter=0, grant=IDLE. wr_ready=0 while reset is high.
- Window: in_win = enable && X0<=x<X0+TILES*TILE && Y0<=y<Y0+TILES*TILE. Half-open bounds, so the default window is x 120..519, y 40..439.
- Grant decision, made in cycle t from inputs at t, with a registered state:
  - DISP if in_win.
  - WRITE if !in_win && wr_valid.
  - IDLE otherwise.
- wr_ready = !reset && !in_win, independent of wr_valid. A transfer occurs when wr_valid && wr_ready. The writer never wins while in_win=1; the display has absolute priority.
- DISP grant at t: at t+1, mem_we=0 and mem_addr = ((by*TILES+bx)*TILE*TILE + ly*TILE + lx), where:
  - bx = (x-X0)/TILE, lx = (x-X0)%TILE
  - by = (y-Y0)/TILE, ly = (y-Y0)%TILE
  - The divider-free form (incremental tile counters) is permitted if results are identical.
- Display read latency: at t+2, pix_valid=1 and pix_data=mem_rdata. pix_valid=0 in cycles whose t-2 grant was not DISP; pix_data holds its last value.
- WRITE grant at t: at t+1, mem_addr=wr_addr, mem_wdata=wr_data, mem_we=1 if wr_addr < TILES*TILES*TILE*TILE.
  - Out-of-range addresses are still accepted (no deadlock) but mem_we=0 and wr_oob sets at t+1.
- IDLE: mem_we=0 at t+1; mem_addr and mem_wdata hold.
- frame_done: pulses at t+2 when the DISP grant at t was x=X0+TILES*TILE-1, y=Y0+TILES*TILE-1.
- Starvation: the wait counter increments each cycle wr_valid && !wr_ready and clears on any transfer or when !wr_valid. starve sets when the counter reaches MAX_WAIT; the counter saturates.
- clear_status clears wr_oob and starve. If a set condition occurs in the same cycle, set wins.
- enable falling mid-frame: the next cycle is no longer DISP, the writer may be granted immediately, and in-flight display reads still complete with pix_valid at their scheduled cycle. Rising enable takes effect on the same-cycle window check.
- Reset mid-operation: the pipeline is flushed, no pix_valid or frame_done is emitted for in-flight reads, and any pending write is discarded (mem_we=0 next cycle).

Test Plan:
- Reset with x=120, y=40, wr_valid=1 -> all outputs 0 and wr_ready=0; the first cycle after release gives wr_ready=0 and mem_addr=0 one cycle later.
- Beam at (120,40), (221,40), (120,141), (519,439) with mem_rdata=addr[7:0] -> mem_addr 0, 10001, 40100, 159999 one cycle later; pix_valid with matching data two cycles later; frame_done only with the 159999 pixel.
- Beam at (520,100) with wr_valid, wr_addr=5, wr_data=0xAA -> wr_ready=1; next cycle mem_we=1, mem_addr=5, mem_wdata=0xAA, pix_valid=0 two cycles later.
- Beam at (300,200) with wr_valid held -> wr_ready=0 and mem_we=0 throughout; after 1023 cycles starve=1; clear_status with beam moved out of the window -> starve=0 and the write completes.
- Write with wr_addr=160000 outside the window -> wr_ready=1, mem_we=0, wr_oob=1 sticky until clear_status.
- enable=0 with beam inside the window and wr_valid -> write granted, pix_valid=0; enable dropped mid-line -> the two in-flight pixels still appear, then pix_valid=0.
